// File: rtl/szorzo.sv
// Sequential shift-add multiply-accumulate: eredmeny = a*b + c.
// Shares the start/ready handshake of the divider so one control FSM can drive both.
module szorzo #(
  parameter int unsigned BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  input  logic [BITS-1:0]   c,
  output logic [2*BITS-1:0] eredmeny,
  output logic              tulcsordulas,
  output logic              ready
);

  localparam int unsigned CntW = $clog2(BITS + 1);
  localparam int unsigned ResW = 2 * BITS;

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StCalc = 2'd1,
    StKesz = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ResW-1:0]   acc_q, acc_d;
  logic [ResW-1:0]   a_sh_q, a_sh_d;
  logic [BITS-1:0]   b_sh_q, b_sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    case (state_q)
      StWait: begin
        if (start) begin
          acc_d   = {{BITS{1'b0}}, c};
          a_sh_d  = {{BITS{1'b0}}, a};
          b_sh_d  = b;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Fixed latency: always BITS iterations, even when b_sh is already zero.
        if (b_sh_q[0]) begin
          acc_d = acc_q + a_sh_q;
        end
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BITS - 1)) begin
          state_d = StKesz;
        end
      end
      StKesz: begin
        if (start) begin
          state_d = StWait;
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWait;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign eredmeny     = acc_q;
  assign ready        = (state_q == StKesz);
  assign tulcsordulas = ready && (acc_q[ResW-1:BITS] != '0);

endmodule

// File: tb/tb_szorzo.sv
// Directed bench for szorzo (BITS=4): latency, results, overflow flag, reset and back-to-back.
module tb_szorzo;

  localparam int unsigned BITS = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [BITS-1:0]   a;
  logic [BITS-1:0]   b;
  logic [BITS-1:0]   c;
  logic [2*BITS-1:0] eredmeny;
  logic              tulcsordulas;
  logic              ready;

  int n_pass;
  int n_total;

  szorzo #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a            (a),
    .b            (b),
    .c            (c),
    .eredmeny     (eredmeny),
    .tulcsordulas (tulcsordulas),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one operation with a single-cycle start pulse and check latency and result.
  task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic [3:0] vc, input logic [7:0] exp_res, input logic exp_ovf,
                        input logic scramble);
    a = va; b = vb; c = vc; start = 1'b1;
    tick();  // sampling edge
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (scramble) begin
        a = 4'(i * 5); b = 4'(~i); c = 4'(i + 8);
      end
      tick();
      check({tag, "_busy"}, 16'(ready), 16'd0);
    end
    tick();
    check({tag, "_ready"}, 16'(ready), 16'd1);
    check({tag, "_res"}, 16'(eredmeny), 16'(exp_res));
    check({tag, "_ovf"}, 16'(tulcsordulas), 16'(exp_ovf));
    tick();
    check({tag, "_hold"}, 16'(eredmeny), 16'(exp_res));
    check({tag, "_stay"}, 16'(ready), 16'd1);
    start = 1'b1;
    tick();  // acknowledge
    start = 1'b0;
    check({tag, "_ack"}, 16'(ready), 16'd0);
    check({tag, "_ackres"}, 16'(eredmeny), 16'(exp_res));
    check({tag, "_ackovf"}, 16'(tulcsordulas), 16'd0);
  endtask

  logic [3:0] va_t [3];
  logic [3:0] vb_t [3];
  logic [3:0] vc_t [3];
  logic [7:0] res_t [3];
  logic       ovf_t [3];

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
    tick();
    rst = 1'b0;
    check("rst_res", 16'(eredmeny), 16'd0);
    check("rst_ready", 16'(ready), 16'd0);
    check("rst_ovf", 16'(tulcsordulas), 16'd0);

    a = 4'd15; b = 4'd15; c = 4'd15;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", {7'd0, ready, tulcsordulas, eredmeny}, 16'd0);
    end

    run_op("mul231", 4'd2, 4'd3, 4'd1, 8'h07, 1'b0, 1'b1);
    run_op("max", 4'd15, 4'd15, 4'd15, 8'hF0, 1'b1, 1'b0);
    run_op("ovf732", 4'd7, 4'd3, 4'd2, 8'h17, 1'b1, 1'b0);
    run_op("bzero", 4'd9, 4'd0, 4'd5, 8'h05, 1'b0, 1'b0);
    run_op("roundtrip", 4'd3, 4'd4, 4'd1, 8'h0D, 1'b0, 1'b0);

    // Reset in the middle of CALC.
    a = 4'd15; b = 4'd15; c = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_res", 16'(eredmeny), 16'd0);
    check("midrst_ready", 16'(ready), 16'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_wait", {8'd0, ready, eredmeny[6:0]}, 16'd0);
    end

    // start held high: ready every 6 cycles, new operands picked up in WAIT.
    va_t[0] = 4'd2; vb_t[0] = 4'd3; vc_t[0] = 4'd1; res_t[0] = 8'h07; ovf_t[0] = 1'b0;
    va_t[1] = 4'd3; vb_t[1] = 4'd4; vc_t[1] = 4'd1; res_t[1] = 8'h0D; ovf_t[1] = 1'b0;
    va_t[2] = 4'd7; vb_t[2] = 4'd3; vc_t[2] = 4'd2; res_t[2] = 8'h17; ovf_t[2] = 1'b1;
    a = va_t[0]; b = vb_t[0]; c = vc_t[0];
    start = 1'b1;
    tick();  // first sampling edge
    for (int n = 1; n <= 18; n++) begin
      tick();
      check("b2b_ready", 16'(ready), 16'((n % 6) == 4));
      if ((n % 6) == 4) begin
        check("b2b_res", 16'(eredmeny), 16'(res_t[n / 6]));
        check("b2b_ovf", 16'(tulcsordulas), 16'(ovf_t[n / 6]));
        if (n / 6 < 2) begin
          a = va_t[n / 6 + 1]; b = vb_t[n / 6 + 1]; c = vc_t[n / 6 + 1];
        end
      end
    end
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
